// File: rtl/run_seq_pkg.sv
// Shared types and helpers for the run sequencer: FSM state encoding and
// the Step counter width derivation.
package run_seq_pkg;

    typedef enum logic [1:0] {IDLE, START, EXEC, HOLD} seq_state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_seq_ctrl_step_counter.sv
// Execute-cycle index counter: cleared by clr, advances on en and wraps to 0
// after N_STEPS-1; last flags the final index.
module step_counter #(
    parameter int N_STEPS = 16,
    parameter int CNT_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_STEPS - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign last  = (count_reg == LAST_IDX);
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = last ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/run_seq_ctrl.sv
// Run sequencer: one Run press gives a clear cycle, N_STEPS shift cycles, then
// Done until Run is released. Optional input synchronizers via RUN_SYNC_EN.
module run_seq_ctrl
    import run_seq_pkg::*;
#(
    parameter  int N_STEPS = 16,
    localparam int CNT_W   = cnt_width(N_STEPS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    output logic             Clr_Ld,
    output logic             Clr_A,
    output logic             Shift_En,
    output logic [CNT_W-1:0] Step,
    output logic             Busy,
    output logic             Done
);

    logic run_s;
    logic clr_ld_s;

`ifdef RUN_SYNC_EN
    // Bit 1 carries Run, bit 0 carries ClearA_LoadB through a two-flop chain.
    logic [1:0] raw_in;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;

    assign raw_in = {Run, ClearA_LoadB};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= raw_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign run_s    = sync2_reg[1];
    assign clr_ld_s = sync2_reg[0];
`else
    assign run_s    = Run;
    assign clr_ld_s = ClearA_LoadB;
`endif

    seq_state_t state_reg;
    seq_state_t state_next;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_last;
    logic [CNT_W-1:0] cnt_value;

    step_counter #(
        .N_STEPS (N_STEPS),
        .CNT_W   (CNT_W)
    ) u_step_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_value),
        .last  (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (run_s) state_next = START;
            end
            START: begin
                cnt_clr    = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                // Run is deliberately not examined: a started run always completes.
                cnt_en = 1'b1;
                if (cnt_last) state_next = HOLD;
            end
            HOLD: begin
                if (!run_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Clr_Ld is the only output with a path from an input.
    assign Clr_Ld   = (state_reg == IDLE) && clr_ld_s;
    assign Clr_A    = (state_reg == START);
    assign Shift_En = (state_reg == EXEC);
    assign Busy     = (state_reg == START) || (state_reg == EXEC);
    assign Done     = (state_reg == HOLD);
    assign Step     = cnt_value;

endmodule

// File: tb/tb_run_seq_ctrl.sv
// Bench for run_seq_ctrl: N_STEPS=16 and N_STEPS=1 instances against a
// cycle-count reference model; honours RUN_SYNC_EN for the 2-cycle input lag.
module tb_run_seq_ctrl;
    import run_seq_pkg::*;

`ifdef RUN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NA = 16;
    localparam int NB = 1;
    localparam int WA = cnt_width(NA);
    localparam int WB = cnt_width(NB);

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Run = 1'b0;
    logic ClearA_LoadB = 1'b0;

    logic a_clr_ld, a_clr_a, a_shift, a_busy, a_done;
    logic [WA-1:0] a_step;
    logic b_clr_ld, b_clr_a, b_shift, b_busy, b_done;
    logic [WB-1:0] b_step;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    run_seq_ctrl #(.N_STEPS(NA)) dut_a (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
        .Clr_Ld(a_clr_ld), .Clr_A(a_clr_a), .Shift_En(a_shift), .Step(a_step),
        .Busy(a_busy), .Done(a_done)
    );

    run_seq_ctrl #(.N_STEPS(NB)) dut_b (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
        .Clr_Ld(b_clr_ld), .Clr_A(b_clr_a), .Shift_En(b_shift), .Step(b_step),
        .Busy(b_busy), .Done(b_done)
    );

    // Reference model: a run is "elapsed cycles since the press was seen".
    // e=0 is the clear cycle, e=1..N are the execute cycles, then Done.
    bit   m_act [2];
    bit   m_hold[2];
    int   m_e   [2];
    logic [1:0] run_hist;
    logic [1:0] cl_hist;
    logic m_run_eff;

    function automatic int n_of(input int i);
        return (i == 0) ? NA : NB;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_hold[i] = 0; m_e[i] = 0;
            end
            run_hist = '0;
            cl_hist  = '0;
        end else begin
            m_run_eff = (LAT == 0) ? Run : run_hist[1];
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    if (m_e[i] == n_of(i)) begin
                        m_act[i] = 0; m_hold[i] = 1;
                    end else begin
                        m_e[i] = m_e[i] + 1;
                    end
                end else if (m_hold[i]) begin
                    if (!m_run_eff) m_hold[i] = 0;
                end else if (m_run_eff) begin
                    m_act[i] = 1; m_e[i] = 0;
                end
            end
            run_hist = {run_hist[0], Run};
            cl_hist  = {cl_hist[0], ClearA_LoadB};
        end
    end

    // {Clr_Ld, Clr_A, Shift_En, Busy, Done, Step[7:0]}
    function automatic logic [12:0] exp_vec(input int i);
        logic idle, cl, sh;
        logic [7:0] st;
        idle = !m_act[i] && !m_hold[i];
        cl   = idle && ((LAT == 0) ? ClearA_LoadB : cl_hist[1]);
        sh   = m_act[i] && (m_e[i] >= 1);
        st   = sh ? 8'(m_e[i] - 1) : 8'd0;
        return {cl, m_act[i] && (m_e[i] == 0), sh, m_act[i], m_hold[i], st};
    endfunction

    function automatic logic [12:0] obs_a();
        return {a_clr_ld, a_clr_a, a_shift, a_busy, a_done, 8'(a_step)};
    endfunction

    function automatic logic [12:0] obs_b();
        return {b_clr_ld, b_clr_a, b_shift, b_busy, b_done, 8'(b_step)};
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs_a() !== exp_vec(0)) begin
            errors++; $display("FAIL reset_a_cl1: got %h expected %h", obs_a(), exp_vec(0));
        end
        checks++;
        if ({a_clr_a, a_shift, a_busy, a_done, 8'(a_step)} !== 12'h000) begin
            errors++; $display("FAIL reset_zero: got %h expected 000", {a_clr_a, a_shift, a_busy, a_done, 8'(a_step)});
        end
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        checks++;
        if (obs_b() !== exp_vec(1)) begin
            errors++; $display("FAIL reset_b: got %h expected %h", obs_b(), exp_vec(1));
        end
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL reset_idle_a cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_full_run();
        int shifts = 0, busys = 0, clras = 0, first_done = -1, b_shifts = 0, b_busys = 0;
        Run = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL full_run_a cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            checks++;
            if (obs_b() !== exp_vec(1)) begin
                errors++; $display("FAIL full_run_b cycle %0d: got %h expected %h", c, obs_b(), exp_vec(1));
            end
            if (a_shift) shifts++;
            if (a_busy) busys++;
            if (a_clr_a) clras++;
            if (b_shift) b_shifts++;
            if (b_busy) b_busys++;
            if (a_done && first_done < 0) first_done = c;
            if (c == 30) Run = 1'b0;
        end
        checks++;
        if (shifts !== 16 || busys !== 17 || clras !== 1) begin
            errors++; $display("FAIL full_run_counts: shift=%0d busy=%0d clra=%0d expected 16/17/1", shifts, busys, clras);
        end
        checks++;
        if (first_done !== 18 + LAT) begin
            errors++; $display("FAIL full_run_done_cycle: got %0d expected %0d", first_done, 18 + LAT);
        end
        checks++;
        if (b_shifts !== 1 || b_busys !== 2) begin
            errors++; $display("FAIL n1_counts: shift=%0d busy=%0d expected 1/2", b_shifts, b_busys);
        end
        $display("test_full_run done");
    endtask

    task automatic test_pulse_run();
        int shifts = 0, dones = 0;
        Run = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge Clk);
            Run = 1'b0;
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL pulse_a cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            if (a_shift) shifts++;
            if (a_done) dones++;
        end
        checks++;
        if (shifts !== 16 || dones !== 1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL pulse_counts: shift=%0d done=%0d busy=%b expected 16/1/0", shifts, dones, a_busy);
        end
        $display("test_pulse_run done");
    endtask

    task automatic test_mid_reset();
        int shifts = 0;
        Run = 1'b1;
        for (int c = 1; c <= 9 + LAT; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL midrst_pre cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
        end
        checks++;
        if (a_step !== WA'(7) || a_shift !== 1'b1) begin
            errors++; $display("FAIL midrst_step7: step=%0d shift=%b expected 7/1", a_step, a_shift);
        end
        #2 Reset = 1'b1; Run = 1'b0;
        #1;
        checks++;
        if (obs_a() !== 13'h0000 || obs_a() !== exp_vec(0)) begin
            errors++; $display("FAIL midrst_async: got %h expected 0000", obs_a());
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL midrst_post cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            if (a_shift) shifts++;
        end
        checks++;
        if (shifts !== 0) begin
            errors++; $display("FAIL midrst_no_shift: got %0d expected 0", shifts);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_clear_load();
        int lds = 0, busys = 0, ld_in_exec = 0;
        ClearA_LoadB = 1'b1; Run = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL clrld_idle cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            if (a_clr_ld) lds++;
            if (a_busy) busys++;
        end
        checks++;
        if (lds !== ((LAT == 0) ? 6 : 7 - LAT) || busys !== 0) begin
            errors++; $display("FAIL clrld_idle_count: ld=%0d busy=%0d expected %0d/0", lds, busys, (LAT == 0) ? 6 : 7 - LAT);
        end
        Run = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL clrld_run cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            if (a_shift && a_clr_ld) ld_in_exec++;
            if (c == 22) Run = 1'b0;
        end
        checks++;
        if (ld_in_exec !== 0) begin
            errors++; $display("FAIL clrld_exec: got %0d cycles expected 0", ld_in_exec);
        end
        ClearA_LoadB = 1'b0;
        $display("test_clear_load done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            checks++;
            if (obs_a() !== exp_vec(0)) begin
                errors++; $display("FAIL random_a cycle %0d: got %h expected %h", c, obs_a(), exp_vec(0));
            end
            checks++;
            if (obs_b() !== exp_vec(1)) begin
                errors++; $display("FAIL random_b cycle %0d: got %h expected %h", c, obs_b(), exp_vec(1));
            end
            if ($urandom_range(7, 0) == 0) Run = ~Run;
            ClearA_LoadB = ($urandom_range(3, 0) == 0);
            Reset = ($urandom_range(149, 0) == 0);
        end
        Reset = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_pulse_run();
        test_mid_reset();
        test_clear_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
